// File: rtl/sys_mem_responder.sv
// sys_mem_responder: system-side memory model answering the cache's Sys* bus.
// Read requests return a 16-word line in offset order 0..15. Write requests
// store one word and are acknowledged once. Every beat is preceded by
// WAIT_STATES idle cycles.
//
// Handshake: a request is accepted only on a rising edge where the FSM is IDLE
// and SysStrobe=1. SysRW, the word index and SysData_in are captured on that
// edge. SysStrobe is ignored while busy and is never queued. SysReady is a
// one-cycle pulse per beat or acknowledge. SysData_out is valid while SysReady=1
// and holds its last value otherwise.
module sys_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 2,
    parameter int BEAT_BITS   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SysStrobe,
    input  logic        SysRW,
    input  logic [31:0] SysAddress,
    input  logic [31:0] SysData_in,
    output logic [31:0] SysData_out,
    output logic        SysReady,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_BEAT = 3'd2,
        WR_WAIT = 3'd3,
        WR_ACK  = 3'd4
    } state_t;

    localparam logic [3:0]           WAIT_LD     = 4'(WAIT_STATES);
    localparam logic [3:0]           WAIT_RELOAD = 4'(WAIT_STATES - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE    = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT   = '1;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [BEAT_BITS-1:0]  beat;
    logic [BEAT_BITS-1:0]  rd_beat;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [31:0]           data_q;
    logic                  wr_en;
    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{SysAddress[31:ADDR_WIDTH+2], SysAddress[1:0]};

    assign dbg_state = state;

    // Reset asserts asynchronously, releases two clock edges after the pin rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Beat whose word is fetched on this edge; back-to-back bursts look one ahead.
    always_comb begin
        rd_beat = beat;
        if (state == RD_BEAT) rd_beat = beat + BEAT_ONE;
    end

    // Line base keeps the upper index bits; the burst never leaves its line.
    assign rd_idx = {idx_q[ADDR_WIDTH-1:BEAT_BITS], rd_beat};

    // The store happens on the same edge that raises the write acknowledge.
    assign wr_en = (state == WR_WAIT) && (wait_cnt == 4'd0);

    // Backing array; never reset so completed writes survive a reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[idx_q] <= data_q;
    end

    // Transaction FSM with registered SysReady/SysData_out.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            SysReady    <= 1'b0;
            SysData_out <= '0;
            wait_cnt    <= '0;
            beat        <= '0;
            idx_q       <= '0;
            data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    SysReady <= 1'b0;
                    if (SysStrobe) begin
                        idx_q    <= SysAddress[ADDR_WIDTH+1:2];
                        data_q   <= SysData_in;
                        wait_cnt <= WAIT_LD;
                        beat     <= '0;
                        state    <= SysRW ? RD_WAIT : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        SysReady    <= 1'b1;
                        SysData_out <= mem[rd_idx];
                        state       <= RD_BEAT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RD_BEAT: begin
                    if (beat == LAST_BEAT) begin
                        SysReady <= 1'b0;
                        state    <= IDLE;
                    end else if (WAIT_STATES == 0) begin
                        SysReady    <= 1'b1;
                        SysData_out <= mem[rd_idx];
                        beat        <= beat + BEAT_ONE;
                    end else begin
                        // This edge already counts as the first wait cycle.
                        SysReady <= 1'b0;
                        beat     <= beat + BEAT_ONE;
                        wait_cnt <= WAIT_RELOAD;
                        state    <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        SysReady <= 1'b1;
                        state    <= WR_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WR_ACK: begin
                    SysReady <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    SysReady <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sys_mem_responder.md
Name: sys_mem_responder

Overview:
- System-side memory responder that answers the cache's Sys* bus: SysStrobe, SysRW, SysAddress, SysData_in, SysData_out and SysReady.
- Serves read misses as 16-word line-fill bursts, returned in offset order 0..15, one SysReady pulse per word.
- Serves write-through stores as single-word writes acknowledged by one SysReady pulse.
- Holds the backing word-addressed storage array and inserts configurable wait states before every beat.

Parameters:
ADDR_WIDTH, 12, word-address bits of backing array (depth 2^ADDR_WIDTH words of 32 bits)
WAIT_STATES, 2, idle cycles inserted before each SysReady pulse (0..15)
BEAT_BITS, 4, log2 of burst length (16 words = one 64-byte cache line)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
SysStrobe  input  1  request strobe from cache, sampled only in IDLE
SysRW  input  1  1 = read (line fill), 0 = write (single word)
SysAddress  input  32  byte address; word index = SysAddress[ADDR_WIDTH+1:2]
SysData_in  input  32  write data from cache
SysData_out  output  32  read data, valid while SysReady=1
SysReady  output  1  one-cycle per-beat/acknowledge pulse

Behaviour:
- Reset (reset=0, async): state=IDLE; SysReady=0; SysData_out=0; beat and wait counters=0. Storage array is not cleared. Deassertion is synchronised internally.
- States:
  - IDLE: waits for a request.
  - RD_WAIT / RD_BEAT: read-burst wait and beat phases.
  - WR_WAIT / WR_ACK: write wait and acknowledge phases.
- Acceptance edge E0: the rising edge where state=IDLE and SysStrobe=1. At E0 latch SysRW, the word index and SysData_in. Load wait counter=WAIT_STATES and beat=0.
- Read: line base = latched word index with low BEAT_BITS forced to 0.
  - Beat k (k=0..15) has SysReady=1 for exactly the cycle after edge E0+(k+1)*(WAIT_STATES+1).
  - SysData_out = mem[base+k] during that cycle.
  - Offset bits of SysAddress never reorder beats; beat 0 is always offset 0.
- Write: mem[index] <= latched data at edge E0+WAIT_STATES+1. SysReady=1 for that following cycle only.
- Completion: the edge ending the last SysReady cycle returns the FSM to IDLE with SysReady=0. The earliest next acceptance is the following edge.
- WAIT_STATES=0: read beats are back-to-back, 16 consecutive SysReady cycles; write ack at E0+1.
- SysStrobe while not IDLE: ignored with no queuing. SysStrobe held high in IDLE is accepted once per transaction.
- SysData_out holds its last value when SysReady=0.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the array size. Line base wrap stays inside a 16-word-aligned line.
- Reset mid-transaction: SysReady drops to 0 immediately and the FSM goes to IDLE. A write whose SysReady edge has not yet occurred is not performed. Completed writes persist.
- Beat counter width BEAT_BITS, wait counter width 4; neither wraps within a transaction.

Test Plan:
1. Reset: hold reset=0 for 3 cycles -> SysReady=0 and SysData_out=0 throughout; no response to SysStrobe=1 during reset.
2. Write, WAIT_STATES=2: SysStrobe=1, SysRW=0, SysAddress=0x00000104, SysData_in=0xDEADBEEF at E0 -> single SysReady cycle after E0+3; mem[0x041]=0xDEADBEEF.
3. Read burst, WAIT_STATES=2, after preloading mem[0x40+k]=0x1000+k: SysAddress=0x00000118, SysRW=1 -> 16 SysReady pulses spaced 3 cycles, first after E0+3, data 0x1000..0x100F in order; FSM returns to IDLE after the last pulse.
4. Busy strobe: pulse SysStrobe again during a burst at beat 4 -> the burst continues unchanged with exactly 16 pulses total; no extra transaction afterwards.
5. Reset mid-burst after beat 5 -> SysReady=0 at once; a new read of the same line returns all 16 original words; earlier writes are retained.
6. WAIT_STATES=0, SysAddress=0x00004104 with ADDR_WIDTH=12: write then read -> write aliases to word 0x041; the read returns 16 back-to-back SysReady cycles with beat 1 = written value.
